// File: rtl/fft_pkg.sv
// Shared types, constants and address helpers for the 512-point radix-2 FFT sequencer.
package fft_pkg;

   localparam int unsigned LOG2N    = 9;
   localparam int unsigned NPTS     = 1 << LOG2N;
   localparam int unsigned NBFLY    = NPTS / 2;
   localparam int unsigned RD_LAT   = 1;
   localparam int unsigned BFLY_LAT = 1;
   localparam int unsigned WR_DLY   = RD_LAT + BFLY_LAT;
   localparam int unsigned STAGE_W  = 4;

   typedef logic [LOG2N-1:0]   adr_t;
   typedef logic [LOG2N-2:0]   bfly_t;
   typedef logic [STAGE_W-1:0] stage_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

   // Payload carried down the write pipe alongside the read addresses.
   typedef struct packed {
      logic we;
      adr_t adr_a;
      adr_t adr_b;
   } wr_req_t;

   // Rotate left within LOG2N bits; s is always below LOG2N.
   function automatic adr_t rotl(input adr_t x, input stage_t s);
      return (x << s) | (x >> (STAGE_W'(LOG2N) - s));
   endfunction

   // Butterfly operand address: pair bit inserted at LSB, then rotated to bit position s.
   function automatic adr_t bfly_adr(input bfly_t b, input logic odd, input stage_t s);
      return rotl({b, odd}, s);
   endfunction

   // Twiddle index keeps only the top s bits of the butterfly counter.
   function automatic adr_t twiddle(input bfly_t b, input stage_t s);
      bfly_t ones;
      ones = '1;
      return {1'b0, b & ~(ones >> s)};
   endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// Fixed-depth shift register used to align write enable/addresses with the butterfly output.
module fft_seq_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   // Shift one stage per cycle; reset flushes every in-flight entry.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the in-place radix-2 FFT: drives ping-pong RAM read/write
// addresses, write enable and twiddle ROM address.
// Optional build macro FFT_SEQ_CYCLE_COUNT_EN adds cycle_count_o (busy-cycle counter).
module fft_stage_sequencer
   import fft_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             rd_bank_o,
   output logic [LOG2N-1:0] rd_adr_a_o,
   output logic [LOG2N-1:0] rd_adr_b_o,
   output logic [LOG2N-1:0] twiddle_address_o,
   output logic             we_o,
   output logic [LOG2N-1:0] wr_adr_a_o,
   output logic [LOG2N-1:0] wr_adr_b_o,
   output logic             result_bank_o,
`ifdef FFT_SEQ_CYCLE_COUNT_EN
   output logic [15:0]      cycle_count_o,
`endif
   output logic [3:0]       stage_o
);

   localparam int unsigned CNT_W = $clog2(WR_DLY + 1);
   typedef logic [CNT_W-1:0] cnt_t;

   seq_state_t state_q;
   logic       busy_q;
   logic       done_q;
   logic       issue_q;
   stage_t     stage_q;
   bfly_t      b_q;
   cnt_t       drain_q;
   adr_t       rd_adr_a_q;
   adr_t       rd_adr_b_q;
   adr_t       twiddle_q;

   bfly_t      b_inc_c;
   stage_t     stage_inc_c;
   logic       last_bfly_c;
   logic       last_stage_c;
   logic       drain_end_c;
   wr_req_t    wr_req_in_c;
   wr_req_t    wr_req_out_c;

   // Counter increments and terminal-count decodes.
   always_comb begin
      b_inc_c      = b_q + bfly_t'(1);
      stage_inc_c  = stage_q + stage_t'(1);
      last_bfly_c  = (b_q == bfly_t'(NBFLY - 1));
      last_stage_c = (stage_q == stage_t'(LOG2N - 1));
      drain_end_c  = (drain_q == cnt_t'(WR_DLY - 1));
   end

   // Sequencer FSM: one butterfly issued per RUN cycle, DRAIN lets the last writes land.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         issue_q    <= 1'b0;
         stage_q    <= '0;
         b_q        <= '0;
         drain_q    <= '0;
         rd_adr_a_q <= '0;
         rd_adr_b_q <= '0;
         twiddle_q  <= '0;
      end else begin
         done_q  <= 1'b0;
         issue_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q    <= RUN;
                  busy_q     <= 1'b1;
                  issue_q    <= 1'b1;
                  stage_q    <= '0;
                  b_q        <= '0;
                  rd_adr_a_q <= bfly_adr('0, 1'b0, '0);
                  rd_adr_b_q <= bfly_adr('0, 1'b1, '0);
                  twiddle_q  <= twiddle('0, '0);
               end
            end
            RUN: begin
               if (last_bfly_c) begin
                  state_q <= DRAIN;
                  drain_q <= '0;
               end else begin
                  issue_q    <= 1'b1;
                  b_q        <= b_inc_c;
                  rd_adr_a_q <= bfly_adr(b_inc_c, 1'b0, stage_q);
                  rd_adr_b_q <= bfly_adr(b_inc_c, 1'b1, stage_q);
                  twiddle_q  <= twiddle(b_inc_c, stage_q);
               end
            end
            DRAIN: begin
               if (!drain_end_c) begin
                  drain_q <= drain_q + cnt_t'(1);
               end else if (last_stage_c) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= RUN;
                  issue_q    <= 1'b1;
                  stage_q    <= stage_inc_c;
                  b_q        <= '0;
                  rd_adr_a_q <= bfly_adr('0, 1'b0, stage_inc_c);
                  rd_adr_b_q <= bfly_adr('0, 1'b1, stage_inc_c);
                  twiddle_q  <= twiddle('0, stage_inc_c);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Writes are the issued reads delayed by RAM read latency plus butterfly latency.
   always_comb begin
      wr_req_in_c       = '0;
      wr_req_in_c.we    = issue_q;
      wr_req_in_c.adr_a = rd_adr_a_q;
      wr_req_in_c.adr_b = rd_adr_b_q;
   end

   fft_seq_delay #(
      .WIDTH ($bits(wr_req_t)),
      .DEPTH (WR_DLY)
   ) u_wr_pipe (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (wr_req_in_c),
      .q_o     (wr_req_out_c)
   );

`ifdef FFT_SEQ_CYCLE_COUNT_EN
   logic [15:0] cycle_count_q;

   // Busy-cycle counter: cleared by an accepted start, frozen once the transform ends.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cycle_count_q <= '0;
      end else if (state_q == IDLE && start_i) begin
         cycle_count_q <= '0;
      end else if (busy_q) begin
         cycle_count_q <= cycle_count_q + 16'd1;
      end
   end

   assign cycle_count_o = cycle_count_q;
`endif

   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign rd_bank_o         = stage_q[0];
   assign rd_adr_a_o        = rd_adr_a_q;
   assign rd_adr_b_o        = rd_adr_b_q;
   assign twiddle_address_o = twiddle_q;
   assign we_o              = wr_req_out_c.we;
   assign wr_adr_a_o        = wr_req_out_c.adr_a;
   assign wr_adr_b_o        = wr_req_out_c.adr_b;
   // Each stage flips the bank, so an odd stage count leaves the spectrum in bank 1.
   assign result_bank_o     = 1'(LOG2N % 2);
   assign stage_o           = stage_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: expected per-cycle outputs and write requests
// are queued at start; a negedge monitor pops and compares them.
module tb_fft_stage_sequencer;

   localparam int N_LOG = 9;
   localparam int N_BF  = 256;
   localparam int LAT   = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy_o, done_o, rd_bank_o, we_o, result_bank_o;
   logic [8:0] rd_adr_a_o, rd_adr_b_o, twiddle_address_o, wr_adr_a_o, wr_adr_b_o;
   logic [3:0] stage_o;
`ifdef FFT_SEQ_CYCLE_COUNT_EN
   logic [15:0] cycle_count_o;
`endif

   fft_stage_sequencer dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .start_i           (start),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .rd_bank_o         (rd_bank_o),
      .rd_adr_a_o        (rd_adr_a_o),
      .rd_adr_b_o        (rd_adr_b_o),
      .twiddle_address_o (twiddle_address_o),
      .we_o              (we_o),
      .wr_adr_a_o        (wr_adr_a_o),
      .wr_adr_b_o        (wr_adr_b_o),
      .result_bank_o     (result_bank_o),
`ifdef FFT_SEQ_CYCLE_COUNT_EN
      .cycle_count_o     (cycle_count_o),
`endif
      .stage_o           (stage_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit busy;
      bit done;
      bit we;
      bit chk_adr;
      int stage;
      int rd_a;
      int rd_b;
      int tw;
   } exp_t;

   typedef struct {
      int stage;
      int a;
      int b;
   } wr_t;

   exp_t cyc_q[$];
   wr_t  wr_q[$];
   bit   issue_hist[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;
   int   we_cnt[N_LOG];

   // Reference: rotate a 9-bit index left by s, one bit at a time.
   function automatic int ref_rot(input int v, input int s);
      int r;
      r = v;
      for (int k = 0; k < s; k++) r = ((r * 2) % 512) + (r / 256);
      return r;
   endfunction

   // Reference: twiddle keeps the top s bits of the 8-bit butterfly index.
   function automatic int ref_tw(input int b, input int s);
      return b - (b % (1 << (N_LOG - 1 - s)));
   endfunction

   task automatic check(input bit ok, input string what);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s", what);
   endtask

   // A write is expected LAT cycles after every issued read.
   task automatic push_rec(input exp_t r, input bit iss);
      exp_t e;
      e = r;
      e.we = (issue_hist.size() >= LAT) ? issue_hist[issue_hist.size() - LAT] : 1'b0;
      cyc_q.push_back(e);
      issue_hist.push_back(iss);
   endtask

   task automatic push_transform();
      exp_t r;
      wr_t  w;
      issue_hist.delete();
      r = '{busy: 1'b1, done: 1'b0, we: 1'b0, chk_adr: 1'b1, stage: 0, rd_a: 0, rd_b: 0, tw: 0};
      for (int s = 0; s < N_LOG; s++) begin
         for (int b = 0; b < N_BF; b++) begin
            r.stage = s;
            r.rd_a  = ref_rot(2 * b, s);
            r.rd_b  = ref_rot(2 * b + 1, s);
            r.tw    = ref_tw(b, s);
            push_rec(r, 1'b1);
            w = '{stage: s, a: r.rd_a, b: r.rd_b};
            wr_q.push_back(w);
         end
         for (int d = 0; d < LAT; d++) push_rec(r, 1'b0);
      end
      r.busy    = 1'b0;
      r.done    = 1'b1;
      r.chk_adr = 1'b0;
      push_rec(r, 1'b0);
   endtask

   function automatic exp_t reset_rec();
      exp_t r;
      r = '{busy: 1'b0, done: 1'b0, we: 1'b0, chk_adr: 1'b1, stage: 0, rd_a: 0, rd_b: 0, tw: 0};
      return r;
   endfunction

   // Monitor: one expected record per cycle while a trace is queued, idle checks otherwise.
   always @(negedge clk) begin : monitor
      exp_t e;
      wr_t  w;
      bit   ok;
      int   st, ra, rb, tw, wa, wb;
      if (mon_en) begin
         st = int'(stage_o);
         ra = int'(rd_adr_a_o);
         rb = int'(rd_adr_b_o);
         tw = int'(twiddle_address_o);
         wa = int'(wr_adr_a_o);
         wb = int'(wr_adr_b_o);
         if (cyc_q.size() != 0) begin
            e  = cyc_q.pop_front();
            ok = (busy_o === e.busy) && (done_o === e.done) && (we_o === e.we);
            if (e.chk_adr)
               ok = ok && (st == e.stage) && (rd_bank_o === 1'(e.stage % 2)) &&
                    (ra == e.rd_a) && (rb == e.rd_b) && (tw == e.tw);
            check(ok, $sformatf("cycle got busy=%0b done=%0b we=%0b stage=%0d bank=%0b rd=%0d/%0d tw=%0d want busy=%0b done=%0b we=%0b stage=%0d rd=%0d/%0d tw=%0d",
                  busy_o, done_o, we_o, st, rd_bank_o, ra, rb, tw,
                  e.busy, e.done, e.we, e.stage, e.rd_a, e.rd_b, e.tw));
         end else begin
            check(busy_o === 1'b0 && done_o === 1'b0 && we_o === 1'b0,
                  $sformatf("idle got busy=%0b done=%0b we=%0b want 0/0/0", busy_o, done_o, we_o));
         end
         if (we_o === 1'b1) begin
            if (st < N_LOG) we_cnt[st]++;
            if (wr_q.size() == 0) begin
               check(1'b0, $sformatf("write got unexpected we at stage=%0d wr=%0d/%0d want no write", st, wa, wb));
            end else begin
               w = wr_q.pop_front();
               check(st == w.stage && wa == w.a && wb == w.b,
                     $sformatf("write got stage=%0d wr=%0d/%0d want stage=%0d wr=%0d/%0d",
                               st, wa, wb, w.stage, w.a, w.b));
            end
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full transform with stray start pulses while busy and in the done cycle.
   task automatic run_full();
      int n;
      bit seen;
      int ia;
      int ib;
      ia = $urandom_range(0, 2321);
      ib = $urandom_range(0, 2321);
      for (int s = 0; s < N_LOG; s++) we_cnt[s] = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      push_transform();
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 3000) begin
         start = (n == ia) || (n == ib);
         @(posedge clk);
         #1;
         n++;
         seen = (done_o === 1'b1);
      end
      check(seen && (n + 1 == 2323),
            $sformatf("latency got %0d cycles (done seen=%0b) want 2323", n + 1, seen));
      check(result_bank_o === 1'b1, $sformatf("result_bank got %0b want 1", result_bank_o));
`ifdef FFT_SEQ_CYCLE_COUNT_EN
      check(cycle_count_o == 16'd2322, $sformatf("cycle_count at done got %0d want 2322", cycle_count_o));
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      idle(4);
`ifdef FFT_SEQ_CYCLE_COUNT_EN
      check(cycle_count_o == 16'd2322, $sformatf("cycle_count hold got %0d want 2322", cycle_count_o));
`endif
      for (int s = 0; s < N_LOG; s++)
         check(we_cnt[s] == N_BF, $sformatf("we count stage %0d got %0d want %0d", s, we_cnt[s], N_BF));
   endtask

   // Transform aborted by reset (with a simultaneous start) in the middle of stage 4.
   task automatic run_reset();
      int n;
      int target;
      target = 4 * (N_BF + LAT) + $urandom_range(5, 250);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      push_transform();
      n = 0;
      while (n < target) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(busy_o === 1'b1 && stage_o == 4'd4,
            $sformatf("pre-reset got busy=%0b stage=%0d want 1/4", busy_o, stage_o));
      reset = 1'b1;
      start = 1'b1;
      while (cyc_q.size() > 1) void'(cyc_q.pop_back());
      cyc_q.push_back(reset_rec());
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      wr_q.delete();
      check(busy_o === 1'b0 && we_o === 1'b0 && stage_o == 4'd0 && done_o === 1'b0,
            $sformatf("post-reset got busy=%0b we=%0b stage=%0d done=%0b want 0/0/0/0",
                      busy_o, we_o, stage_o, done_o));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog timeout with %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int guard;
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      cyc_q.push_back(reset_rec());
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle($urandom_range(2, 6));
      run_full();
      idle($urandom_range(2, 6));
      run_reset();
      idle($urandom_range(2, 6));
      run_full();
      idle(5);
      guard = 0;
      while (cyc_q.size() != 0 && guard < 100) begin
         idle(1);
         guard++;
      end
      check(cyc_q.size() == 0, $sformatf("trace drain got %0d entries left want 0", cyc_q.size()));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
